// File: rtl/audio_output_stage.sv
`default_nettype none
// ============================================================================
// Module   : audio_output_stage
// Brief    : Multi-channel output path: 2-deep frame FIFO, ramped per-channel
//            volume and mute, first-order sigma-delta PDM, underrun flagging.
//            Optional macro AUDIO_UNDERRUN_COUNT_EN builds a saturating
//            underrun counter.
// Revision : 1.0
// ============================================================================
module audio_output_stage #(
    parameter int WIDTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int VOL_BITS   = 4,
    parameter int RAMP_TICKS = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [CHANNELS*WIDTH-1:0]    sample_in,
    input  logic                         sample_valid_in,
    output logic                         sample_ready_out,
    input  logic                         sample_tick_in,
    input  logic [CHANNELS*VOL_BITS-1:0] vol_in,
    input  logic [CHANNELS-1:0]          mute_in,
    output logic [CHANNELS-1:0]          pdm_out,
    output logic                         underrun_out,
    output logic [15:0]                  underrun_count_out
);

    localparam int MAXV = (1 << VOL_BITS) - 1;
    localparam int RW   = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;

    logic [CHANNELS*WIDTH-1:0]        mem [2];
    logic                             wr_ptr;
    logic                             rd_ptr;
    logic [1:0]                       count;
    logic [1:0]                       count_next;
    logic                             push;
    logic                             pop;
    logic [CHANNELS*WIDTH-1:0]        frame;
    logic [RW-1:0]                    ramp;
    logic                             ramp_wrap;

    logic [CHANNELS-1:0][VOL_BITS-1:0] cur_vol;
    logic [CHANNELS-1:0][VOL_BITS-1:0] target;
    logic [CHANNELS-1:0][VOL_BITS-1:0] vol_next;
    logic [CHANNELS-1:0][WIDTH-1:0]    level;
    logic [CHANNELS-1:0][WIDTH-1:0]    scaled;
    logic [CHANNELS-1:0][WIDTH:0]      acc;
    logic [CHANNELS-1:0][WIDTH:0]      acc_next;

    assign push      = sample_valid_in && sample_ready_out;
    assign pop       = sample_tick_in && (count != 2'd0);
    assign ramp_wrap = sample_tick_in && (ramp == RW'(RAMP_TICKS - 1));

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 2'd1;
            2'b01:   count_next = count - 2'd1;
            default: count_next = count;
        endcase
    end

    // Ready is registered from the next occupancy so it never depends on valid.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem[0]           <= '0;
            mem[1]           <= '0;
            wr_ptr           <= 1'b0;
            rd_ptr           <= 1'b0;
            count            <= 2'd0;
            sample_ready_out <= 1'b1;
            frame            <= '0;
            underrun_out     <= 1'b0;
            ramp             <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= sample_in;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                frame  <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            count            <= count_next;
            sample_ready_out <= (count_next != 2'd2);
            underrun_out     <= sample_tick_in && (count == 2'd0);
            if (sample_tick_in) begin
                ramp <= ramp_wrap ? '0 : ramp + 1'b1;
            end
        end
    end

    always_comb begin
        target   = '0;
        vol_next = '0;
        scaled   = '0;
        acc_next = '0;
        pdm_out  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            target[c] = mute_in[c] ? '0 : vol_in[c*VOL_BITS +: VOL_BITS];
            vol_next[c] = cur_vol[c];
            if (cur_vol[c] < target[c]) begin
                vol_next[c] = cur_vol[c] + 1'b1;
            end else if (cur_vol[c] > target[c]) begin
                vol_next[c] = cur_vol[c] - 1'b1;
            end
            scaled[c] = $signed(frame[c*WIDTH +: WIDTH]) >>> (VOL_BITS'(MAXV) - cur_vol[c]);
            // Fully ramped-down mute is true silence, not the residual frame >>> MAXV.
            if (mute_in[c] && (cur_vol[c] == '0)) begin
                scaled[c] = '0;
            end
            acc_next[c] = {1'b0, acc[c][WIDTH-1:0]}
                        + {1'b0, ~level[c][WIDTH-1], level[c][WIDTH-2:0]};
            pdm_out[c]  = acc[c][WIDTH];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cur_vol <= '0;
            level   <= '0;
            acc     <= '0;
        end else begin
            if (ramp_wrap) begin
                cur_vol <= vol_next;
            end
            level <= scaled;
            acc   <= acc_next;
        end
    end

`ifdef AUDIO_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            underrun_count <= 16'd0;
        end else if (underrun_out && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end

    assign underrun_count_out = underrun_count;
`else
    assign underrun_count_out = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_output_stage.sv
`default_nettype none
// Self-checking bench for audio_output_stage: frame scoreboard, volume ramp
// model, PDM density measurement, underrun and reset behaviour.
module tb_audio_output_stage;

    logic        clk;
    logic        rst;
    logic [31:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        sample_tick;
    logic [7:0]  vol;
    logic [1:0]  mute;
    logic [1:0]  pdm;
    logic        underrun;
    logic [15:0] ucount;

    logic        r1_tick;
    logic [7:0]  r1_vol;
    logic        r1_ready;
    logic [1:0]  r1_pdm;
    logic        r1_underrun;
    logic [15:0] r1_ucount;

    int passed = 0;
    int total  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_frame;
    int          m_vol[2];
    int          m_ramp;
    int          m_ucnt;

    audio_output_stage #(.WIDTH(16), .CHANNELS(2), .VOL_BITS(4), .RAMP_TICKS(4)) dut (
        .clk_in             (clk),
        .rst_in             (rst),
        .sample_in          (sample_in),
        .sample_valid_in    (sample_valid),
        .sample_ready_out   (sample_ready),
        .sample_tick_in     (sample_tick),
        .vol_in             (vol),
        .mute_in            (mute),
        .pdm_out            (pdm),
        .underrun_out       (underrun),
        .underrun_count_out (ucount)
    );

    audio_output_stage #(.WIDTH(16), .CHANNELS(2), .VOL_BITS(4), .RAMP_TICKS(1)) dut_r1 (
        .clk_in             (clk),
        .rst_in             (rst),
        .sample_in          (32'd0),
        .sample_valid_in    (1'b0),
        .sample_ready_out   (r1_ready),
        .sample_tick_in     (r1_tick),
        .vol_in             (r1_vol),
        .mute_in            (2'b00),
        .pdm_out            (r1_pdm),
        .underrun_out       (r1_underrun),
        .underrun_count_out (r1_ucount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one cycle of stimulus and advances the reference model.
    task automatic drive(input bit tk, input bit vl, input logic [31:0] data,
                         output bit accepted, output bit under);
        int tgt;
        sample_tick  = tk;
        sample_valid = vl;
        sample_in    = data;
        accepted     = vl && (exp_q.size() < 2);
        under        = tk && (exp_q.size() == 0);
        @(posedge clk);
        #1;
        sample_tick  = 1'b0;
        sample_valid = 1'b0;
        if (tk) begin
            if (!under) m_frame = exp_q.pop_front();
            else if (m_ucnt < 65535) m_ucnt++;
            if (m_ramp == 3) begin
                m_ramp = 0;
                for (int c = 0; c < 2; c++) begin
                    tgt = mute[c] ? 0 : int'(vol[c*4 +: 4]);
                    if (m_vol[c] < tgt) m_vol[c]++;
                    else if (m_vol[c] > tgt) m_vol[c]--;
                end
            end else begin
                m_ramp++;
            end
        end
        if (accepted) exp_q.push_back(data);
    endtask

    task automatic count_ones(input int cycles, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1);
            c0 += int'(pdm[0]);
            c1 += int'(pdm[1]);
        end
    endtask

    task automatic test_reset;
        total++; if (sample_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", sample_ready); else passed++;
        total++; if (pdm !== 2'b00) $display("FAIL reset_pdm: got %b required 00", pdm); else passed++;
        total++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b required 0", underrun); else passed++;
        total++; if (ucount !== 16'd0) $display("FAIL reset_count: got %h required 0000", ucount); else passed++;
        total++; if (dut.cur_vol !== 8'h00) $display("FAIL reset_cur_vol: got %h required 00", dut.cur_vol); else passed++;
    endtask

    task automatic test_ramp_up;
        bit a, u;
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 1'b0, 32'd0, a, u);
            step(1);
        end
        total++;
        if (dut.cur_vol !== {4'(m_vol[1]), 4'(m_vol[0])})
            $display("FAIL ramp_up_vol: got %h required %h", dut.cur_vol, {4'(m_vol[1]), 4'(m_vol[0])});
        else passed++;
    endtask

    task automatic test_density;
        bit a, u;
        int c0, c1;
        drive(1'b0, 1'b1, {16'h1000, 16'hF000}, a, u);
        drive(1'b1, 1'b0, 32'd0, a, u);
        total++; if (underrun !== 1'b0) $display("FAIL density_underrun: got %b required 0", underrun); else passed++;
        total++; if (dut.frame !== m_frame) $display("FAIL density_frame: got %h required %h", dut.frame, m_frame); else passed++;
        step(1);
        total++; if (dut.level !== 32'h1000F000) $display("FAIL density_level: got %h required 1000f000", dut.level); else passed++;
        step(2);
        count_ones(4096, c0, c1);
        total++; if (c0 < 1791 || c0 > 1793) $display("FAIL density_ch0: got %0d required 1792+-1", c0); else passed++;
        total++; if (c1 < 2303 || c1 > 2305) $display("FAIL density_ch1: got %0d required 2304+-1", c1); else passed++;
    endtask

    task automatic test_back_to_back;
        bit a, u;
        drive(1'b0, 1'b1, 32'h11112222, a, u);
        total++; if (sample_ready !== 1'b1) $display("FAIL b2b_ready1: got %b required 1", sample_ready); else passed++;
        drive(1'b0, 1'b1, 32'h33334444, a, u);
        total++; if (sample_ready !== 1'b0) $display("FAIL b2b_ready2: got %b required 0", sample_ready); else passed++;
        drive(1'b0, 1'b1, 32'h55556666, a, u);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 32'd0, a, u);
            total++; if (dut.frame !== m_frame) $display("FAIL b2b_pop%0d: got %h required %h", k, dut.frame, m_frame); else passed++;
            total++; if (underrun !== 1'b0) $display("FAIL b2b_under%0d: got %b required 0", k, underrun); else passed++;
        end
        drive(1'b1, 1'b0, 32'd0, a, u);
        total++; if (underrun !== u) $display("FAIL b2b_third_refused: got %b required %b", underrun, u); else passed++;
        step(1);
    endtask

    task automatic test_underrun;
        bit a, u;
        int exp_cnt;
        drive(1'b0, 1'b1, 32'h7FFF7FFF, a, u);
        drive(1'b1, 1'b0, 32'd0, a, u);
        step(1);
        drive(1'b1, 1'b0, 32'd0, a, u);
        total++; if (underrun !== 1'b1) $display("FAIL under_pulse: got %b required 1", underrun); else passed++;
        total++; if (dut.frame !== m_frame) $display("FAIL under_hold: got %h required %h", dut.frame, m_frame); else passed++;
        step(1);
        total++; if (underrun !== 1'b0) $display("FAIL under_width: got %b required 0", underrun); else passed++;
        total++; if (dut.level !== 32'h7FFF7FFF) $display("FAIL under_level: got %h required 7fff7fff", dut.level); else passed++;
`ifdef AUDIO_UNDERRUN_COUNT_EN
        exp_cnt = m_ucnt;
`else
        exp_cnt = 0;
`endif
        total++; if (ucount !== 16'(exp_cnt)) $display("FAIL under_count: got %h required %h", ucount, 16'(exp_cnt)); else passed++;
        // Push into an empty FIFO on a tick cycle: underrun, frame stays queued.
        drive(1'b1, 1'b1, 32'h0ABC0DEF, a, u);
        total++; if (underrun !== 1'b1) $display("FAIL push_tick_under: got %b required 1", underrun); else passed++;
        drive(1'b1, 1'b0, 32'd0, a, u);
        total++; if (dut.frame !== m_frame) $display("FAIL push_tick_frame: got %h required %h", dut.frame, m_frame); else passed++;
        step(1);
    endtask

    task automatic test_mute_ramp;
        bit a, u;
        int c0, c1;
        drive(1'b0, 1'b1, 32'h40004000, a, u);
        drive(1'b1, 1'b0, 32'd0, a, u);
        mute = 2'b01;
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 32'd0, a, u);
            total++;
            if (dut.cur_vol !== {4'(m_vol[1]), 4'(m_vol[0])})
                $display("FAIL mute_vol_tick%0d: got %h required %h", i, dut.cur_vol, {4'(m_vol[1]), 4'(m_vol[0])});
            else passed++;
        end
        step(3);
        total++; if (dut.level !== 32'h40000000) $display("FAIL mute_level: got %h required 40000000", dut.level); else passed++;
        count_ones(4096, c0, c1);
        total++; if (c0 < 2047 || c0 > 2049) $display("FAIL mute_density: got %0d required 2048+-1", c0); else passed++;
        mute = 2'b00;
    endtask

    task automatic test_ramp1;
        r1_vol = 8'h0F;
        for (int i = 1; i <= 16; i++) begin
            r1_tick = 1'b1;
            step(1);
            r1_tick = 1'b0;
            total++;
            if (dut_r1.cur_vol !== {4'd0, 4'((i > 15) ? 15 : i)})
                $display("FAIL ramp1_step%0d: got %h required %h", i, dut_r1.cur_vol, {4'd0, 4'((i > 15) ? 15 : i)});
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        bit a, u;
        drive(1'b0, 1'b1, 32'h12345678, a, u);
        drive(1'b0, 1'b1, 32'h9ABCDEF0, a, u);
        total++; if (sample_ready !== 1'b0) $display("FAIL rstmid_full: got %b required 0", sample_ready); else passed++;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (pdm !== 2'b00) $display("FAIL rstmid_pdm: got %b required 00", pdm); else passed++;
        total++; if (sample_ready !== 1'b1) $display("FAIL rstmid_ready: got %b required 1", sample_ready); else passed++;
        total++; if (dut.count !== 2'd0) $display("FAIL rstmid_count: got %0d required 0", dut.count); else passed++;
        total++; if (dut.cur_vol !== 8'h00) $display("FAIL rstmid_vol: got %h required 00", dut.cur_vol); else passed++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_frame = 32'd0;
        m_vol[0] = 0; m_vol[1] = 0; m_ramp = 0; m_ucnt = 0;
        drive(1'b1, 1'b0, 32'd0, a, u);
        total++; if (underrun !== 1'b1) $display("FAIL rstmid_first_tick: got %b required 1", underrun); else passed++;
        step(1);
    endtask

`ifdef AUDIO_UNDERRUN_COUNT_EN
    task automatic test_count_saturate;
        bit a, u;
        for (int i = 0; i < 70000; i++) drive(1'b1, 1'b0, 32'd0, a, u);
        step(2);
        total++; if (ucount !== 16'hFFFF) $display("FAIL count_sat: got %h required ffff", ucount); else passed++;
    endtask
`endif

    initial begin
        rst = 1'b1;
        sample_in = 32'd0; sample_valid = 1'b0; sample_tick = 1'b0;
        vol = 8'hFF; mute = 2'b00;
        r1_tick = 1'b0; r1_vol = 8'h00;
        m_frame = 32'd0; m_vol[0] = 0; m_vol[1] = 0; m_ramp = 0; m_ucnt = 0;
        step(3);
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        step(1);
        test_ramp1;
        test_ramp_up;
        test_density;
        test_back_to_back;
        test_underrun;
        test_mute_ramp;
        test_reset_mid;
`ifdef AUDIO_UNDERRUN_COUNT_EN
        test_count_saturate;
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/audio_output_stage.md
Name: audio_output_stage

Overview:
- Multi-channel successor to the single-channel volume/PDM output path.
- Takes packed sample frames from the synthesis/playback pipeline through a valid/ready handshake into a 2-deep frame FIFO.
- Applies per-channel volume with zipper-free ramping and mute.
- Drives one first-order sigma-delta PDM bit per channel to the audio pins. Underrun is detected and flagged.

Parameters:
WIDTH, 16, signed sample width per channel (8..24)
CHANNELS, 2, number of independent output channels (1..8)
VOL_BITS, 4, volume control width; MAXV = 2^VOL_BITS-1 = full scale
RAMP_TICKS, 4, sample ticks per one-step volume change (>=1)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
sample_in  input  CHANNELS*WIDTH  packed signed frame; channel c at [c*WIDTH +: WIDTH]
sample_valid_in  input  1  frame on sample_in is valid
sample_ready_out  output  1  FIFO can accept a frame
sample_tick_in  input  1  single-cycle audio-rate strobe; consumes one frame
vol_in  input  CHANNELS*VOL_BITS  per-channel target volume
mute_in  input  CHANNELS  per-channel mute request
pdm_out  output  CHANNELS  per-channel PDM bitstream
underrun_out  output  1  single-cycle pulse when a tick finds the FIFO empty
underrun_count_out  output  16  saturating underrun count (see Optional Feature)

Behaviour:
- Reset (async assert, sync release): FIFO empty; sample_ready_out=1; frame register, levels and accumulators all 0; cur_vol=0 for all channels; pdm_out=0; underrun_out=0; underrun_count_out=0; ramp counter=0.
- Push: write when sample_valid_in && sample_ready_out.
- sample_ready_out = !full, registered from occupancy.
- Pop: happens on sample_tick_in when the FIFO is non-empty.
- Simultaneous push and pop on a full FIFO: the push is refused because ready=0.
- Simultaneous push and pop on a non-empty, non-full FIFO: occupancy is unchanged.
- Push into an empty FIFO on the same cycle as a tick: that frame is not popped, so an underrun occurs.
- Underrun (tick with FIFO empty):
  - Frame register holds the previous frame, i.e. the last samples are repeated.
  - underrun_out pulses high for the cycle after the tick.
- Latency:
  - Tick at cycle T.
  - Frame register updated at T+1.
  - Scaled level registered at T+2.
  - pdm_out reflects the new level from T+3 onward.
- Volume:
  - target = mute_in[c] ? 0 : vol_in[c].
  - The ramp counter increments on every sample_tick_in and wraps at RAMP_TICKS-1.
  - On wrap, each cur_vol[c] moves exactly one step toward its target; it is unchanged if equal.
  - No jumps greater than one step.
- Scaling, per channel:
  - level = frame[c] >>> (MAXV - cur_vol[c]), arithmetic shift.
  - If cur_vol[c]==0 and mute_in[c]=1, level is forced to 0.
  - If unmuted, volume 0 still passes frame >>> MAXV.
- PDM, per channel, every clk_in cycle:
  - u = level with its MSB inverted (offset binary).
  - acc (WIDTH+1 bits) = acc[WIDTH-1:0] + u.
  - pdm_out[c] = acc[WIDTH], registered.
  - Level 0 produces a 50% density; the most negative level produces all zeros; the most positive level produces density (2^WIDTH-1)/2^WIDTH.
- Reset mid-operation: all state clears immediately, including FIFO contents, ramp position and accumulators. No output glitch beyond pdm_out going to 0.

Optional Feature:
- Macro: AUDIO_UNDERRUN_COUNT_EN.
- Defined: underrun_count_out increments on every underrun_out pulse and saturates at 16'hFFFF. It clears only on reset.
- Undefined: the counter logic is not built and underrun_count_out is tied to 0. underrun_out is still produced.

Test Plan:
- Reset, then push frame {ch1=16'h1000, ch0=16'hF000} with vol_in all 15 and one tick -> at T+2 levels are +4096 and -4096. Over 65536 cycles, pdm_out[0] ones count = 28672 ±1 and pdm_out[1] ones count = 36864 ±1.
- Push 3 frames back-to-back with no ticks -> sample_ready_out=1 after the first push and 0 after the second; the third frame is not accepted. Two ticks pop frames 1 then 2, in order.
- Tick with the FIFO empty after frame 0x7FFF -> underrun_out high for exactly 1 cycle; level stays 0x7FFF>>>shift. With AUDIO_UNDERRUN_COUNT_EN, count=1; 70000 underruns leave count=16'hFFFF.
- RAMP_TICKS=4, cur_vol=15, set mute_in[0]=1, apply 64 ticks -> cur_vol[0] decreases by 1 every 4 ticks and reaches 0 at tick 60. level[0]=0 from then on and pdm_out[0] has 50% density. Channel 1 is unaffected.
- vol_in[0] changes 0->15 with RAMP_TICKS=1 -> cur_vol[0] steps 0,1,...,15 over 15 ticks, never by more than one.
- Assert rst_in asynchronously mid-stream with the FIFO holding 2 frames -> pdm_out=0, sample_ready_out=1, FIFO empty, cur_vol=0 in the same cycle. The first tick after release is an underrun.
